// File: rtl/popcount_pkg.sv
// popcount_pkg: shared constants, width helpers and types for popcount_arbiter.
//   POP_DATA_W  beat width fed to the popcount unit
//   POP_W       width of a single-beat popcount (0..64)
//   cnt_w/id_w/beat_w  derive result port widths from NUM_REQ / MAX_BEATS
//   pc_state_e  arbiter FSM states
//   res_t       per-packet result record, sized for the largest legal
//               configuration (NUM_REQ <= 16, MAX_BEATS <= 65535)
package popcount_pkg;

  localparam int unsigned POP_DATA_W = 64;
  localparam int unsigned POP_W      = 7;

  function automatic int cnt_w(input int max_beats);
    return POP_W + $clog2(max_beats) + 1;
  endfunction

  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int beat_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, RESULT} pc_state_e;

  typedef struct packed {
    logic [23:0] count;
    logic [3:0]  id;
    logic [15:0] beats;
    logic        trunc;
  } res_t;

endpackage

// File: rtl/count_ones.sv
// count_ones: combinational population count of one data word.
//   en     in   gate; output is zero when low
//   d_in   in   DATA_W data word
//   count  out  number of set bits in d_in
module count_ones #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OUT_W  = 7
) (
  input  logic              en,
  input  logic [DATA_W-1:0] d_in,
  output logic [OUT_W-1:0]  count
);

  always_comb begin
    count = '0;
    if (en) begin
      count = OUT_W'($countones(d_in));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req  in   request vector, one bit per requester
//   ptr  in   highest-priority index; search runs upward from here, wrapping
//   gnt  out  one-hot grant (zero when no request)
//   id   out  encoded index of gnt
//   any  out  at least one request present
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);

  logic [ID_W-1:0] sel;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel = ID_W'((32'(ptr) + i) % N);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        id       = sel;
      end
    end
  end

endmodule

// File: rtl/popcount_arbiter.sv
// popcount_arbiter: shares one 64-bit popcount datapath between NUM_REQ
// packet sources. Whole packets are granted round-robin; the ones count is
// accumulated over all beats and returned once per packet with the source id.
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/ready/last   per-requester beat handshake (ready one-hot in BUSY)
//   req_data               NUM_REQ x 64 beat data, requester i at [64*i +: 64]
//   res_valid/res_ready    result handshake; res_* held while stalled
//   res_count              ones in the packet
//   res_id                 requester that sent the packet
//   res_beats              beats in the packet, 1..MAX_BEATS
//   res_trunc              packet force-closed at MAX_BEATS without req_last
// Optional feature, macro POPCNT_STATS_EN: adds stat_sel / stat_pkts, a
// per-requester 16-bit saturating count of delivered results.
module popcount_arbiter
  import popcount_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*POP_DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [cnt_w(MAX_BEATS)-1:0]       res_count,
  output logic [id_w(NUM_REQ)-1:0]          res_id,
  output logic [beat_w(MAX_BEATS)-1:0]      res_beats,
  output logic                              res_trunc
`ifdef POPCNT_STATS_EN
  ,
  input  logic [id_w(NUM_REQ)-1:0]          stat_sel,
  output logic [15:0]                       stat_pkts
`endif
);

  localparam int unsigned CNT_W  = cnt_w(MAX_BEATS);
  localparam int unsigned ID_W   = id_w(NUM_REQ);
  localparam int unsigned BEAT_W = beat_w(MAX_BEATS);

  pc_state_e state, state_nxt;

  logic [ID_W-1:0]       grant, rr_ptr, arb_id;
  logic [NUM_REQ-1:0]    grant_oh, arb_gnt;
  logic                  arb_any;
  logic [CNT_W-1:0]      acc, acc_sum;
  logic [BEAT_W-1:0]     beats, beats_sum;
  logic [POP_DATA_W-1:0] data_arr [NUM_REQ];
  logic [POP_DATA_W-1:0] beat_data;
  logic [POP_W-1:0]      beat_ones;
  logic                  beat_acc, beat_last, close_pkt;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*POP_DATA_W +: POP_DATA_W];
  end

  assign beat_data = data_arr[grant];
  assign beat_acc  = |(req_valid & req_ready);
  assign beat_last = |(req_last & grant_oh);

  count_ones #(.DATA_W(POP_DATA_W), .OUT_W(POP_W)) u_pop (
    .en    (beat_acc),
    .d_in  (beat_data),
    .count (beat_ones)
  );

  assign acc_sum   = acc + CNT_W'(beat_ones);
  assign beats_sum = beats + BEAT_W'(1);
  // A beat that is last or fills the packet closes it; trunc only in the latter case.
  assign close_pkt = beat_acc && (beat_last || (beats_sum == BEAT_W'(MAX_BEATS)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        req_ready = grant_oh;
        if (close_pkt) begin
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      grant_oh  <= '0;
      rr_ptr    <= '0;
      acc       <= '0;
      beats     <= '0;
      res_count <= '0;
      res_id    <= '0;
      res_beats <= '0;
      res_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant    <= arb_id;
            grant_oh <= arb_gnt;
            acc      <= '0;
            beats    <= '0;
          end
        end
        BUSY: begin
          if (beat_acc) begin
            acc   <= acc_sum;
            beats <= beats_sum;
          end
          if (close_pkt) begin
            res_count <= acc_sum;
            res_id    <= grant;
            res_beats <= beats_sum;
            res_trunc <= ~beat_last;
          end
        end
        RESULT: begin
          if (res_ready) begin
            rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef POPCNT_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else if (res_valid && res_ready && (stat_cnt[res_id] != '1)) begin
      stat_cnt[res_id] <= stat_cnt[res_id] + 16'd1;
    end
  end

  assign stat_pkts = (32'(stat_sel) < NUM_REQ) ? stat_cnt[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_popcount_arbiter.sv
// tb_popcount_arbiter: randomized and directed bench for popcount_arbiter.
// Expected results come from per-requester beat streams split into packets
// (on last or on reaching MAX_BEATS) and scored per id in arrival order.
module tb_popcount_arbiter;
  import popcount_pkg::*;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAX_BEATS = 16;
  localparam int unsigned CNT_W     = cnt_w(MAX_BEATS);
  localparam int unsigned ID_W      = id_w(NUM_REQ);
  localparam int unsigned BEAT_W    = beat_w(MAX_BEATS);

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*64-1:0]     req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [CNT_W-1:0]          res_count;
  logic [ID_W-1:0]           res_id;
  logic [BEAT_W-1:0]         res_beats;
  logic                      res_trunc;
`ifdef POPCNT_STATS_EN
  logic [ID_W-1:0]           stat_sel;
  logic [15:0]               stat_pkts;
`endif

  popcount_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_id    (res_id),
    .res_beats (res_beats),
    .res_trunc (res_trunc)
`ifdef POPCNT_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_pkts (stat_pkts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t       beat_q [NUM_REQ][$];
  res_t        exp_q  [NUM_REQ][$];
  res_t        log_q  [$];
  int unsigned pend_sum  [NUM_REQ];
  int unsigned pend_cnt  [NUM_REQ];
  int unsigned acc_total [NUM_REQ];
  logic [NUM_REQ-1:0] acc_mask;
  int unsigned n_vec, n_err;
  int unsigned bubble_pct, rdy_mode;
  logic        hold_prev;
  logic [CNT_W+ID_W+BEAT_W:0] held_bits;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic enq_beat(input int unsigned r, input logic [63:0] d, input logic l);
    beat_t b;
    res_t  e;
    b.d = d;
    b.l = l;
    beat_q[r].push_back(b);
    pend_sum[r] += $countones(d);
    pend_cnt[r]++;
    if (l || pend_cnt[r] == MAX_BEATS) begin
      e       = '0;
      e.count = 24'(pend_sum[r]);
      e.id    = 4'(r);
      e.beats = 16'(pend_cnt[r]);
      e.trunc = !l;
      exp_q[r].push_back(e);
      pend_sum[r] = 0;
      pend_cnt[r] = 0;
    end
  endtask

  // kind: 0 random, 1 all zeros, 2 all ones, 3 sparse
  task automatic enq_pkt(input int unsigned r, input int unsigned n, input int unsigned kind);
    logic [63:0] d;
    for (int unsigned i = 0; i < n; i++) begin
      case (kind)
        0:       d = {$urandom, $urandom};
        1:       d = '0;
        2:       d = '1;
        default: d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      enq_beat(r, d, i == n - 1);
    end
  endtask

  function automatic bit all_empty();
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (beat_q[r].size() != 0 || exp_q[r].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic flush();
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      beat_q[r].delete();
      exp_q[r].delete();
      pend_sum[r] = 0;
      pend_cnt[r] = 0;
    end
    acc_mask  = '0;
    hold_prev = 1'b0;
    req_valid = '0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_res_valid"}, 64'(res_valid), 64'd0);
    check({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    check({pfx, "_res_count"}, 64'(res_count), 64'd0);
    check({pfx, "_res_id"},    64'(res_id),    64'd0);
    check({pfx, "_res_beats"}, 64'(res_beats), 64'd0);
    check({pfx, "_res_trunc"}, 64'(res_trunc), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int unsigned budget);
    bit done;
    done = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (all_empty() && !res_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  // Monitor (mid-cycle) and driver (just after the rising edge).
  initial begin : drv_mon
    beat_t b;
    res_t  got, e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        acc_mask = req_valid & req_ready;
        for (int r = 0; r < NUM_REQ; r++) if (acc_mask[r]) acc_total[r]++;
        check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        if (res_valid) check("ready_in_result", 64'(req_ready), 64'd0);
        if (hold_prev) begin
          check("res_valid_held", 64'(res_valid), 64'd1);
          check("res_stable", 64'({res_count, res_id, res_beats, res_trunc}), 64'(held_bits));
        end
        hold_prev = res_valid && !res_ready;
        held_bits = {res_count, res_id, res_beats, res_trunc};
        if (res_valid && res_ready) begin
          got       = '0;
          got.count = 24'(res_count);
          got.id    = 4'(res_id);
          got.beats = 16'(res_beats);
          got.trunc = res_trunc;
          log_q.push_back(got);
          check("exp_avail", 64'(exp_q[res_id].size() != 0), 64'd1);
          if (exp_q[res_id].size() != 0) begin
            e = exp_q[res_id].pop_front();
            check("res_count", 64'(res_count), 64'(e.count));
            check("res_beats", 64'(res_beats), 64'(e.beats));
            check("res_trunc", 64'(res_trunc), 64'(e.trunc));
          end
        end
      end else begin
        acc_mask  = '0;
        hold_prev = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (acc_mask[r] && beat_q[r].size() != 0) b = beat_q[r].pop_front();
      end
      acc_mask = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (beat_q[r].size() != 0 && $urandom_range(99) >= bubble_pct) begin
          req_valid[r]         = 1'b1;
          req_data[r*64 +: 64] = beat_q[r][0].d;
          req_last[r]          = beat_q[r][0].l;
        end else begin
          req_valid[r]         = 1'b0;
          req_data[r*64 +: 64] = {$urandom, $urandom};
          req_last[r]          = 1'($urandom_range(1));
        end
      end
      case (rdy_mode)
        1:       res_ready = 1'b1;
        2:       res_ready = 1'b0;
        default: res_ready = ($urandom_range(99) < 70);
      endcase
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned lat, start;
    bit found;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b0;
    bubble_pct = 0; rdy_mode = 1; hold_prev = 1'b0; acc_mask = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      pend_sum[r] = 0; pend_cnt[r] = 0; acc_total[r] = 0;
    end
`ifdef POPCNT_STATS_EN
    stat_sel = '0;
`endif
    do_reset();

    // 1-beat all-ones packet: count 64, result two cycles after valid
    log_q.delete();
    enq_pkt(0, 1, 2);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_valid[0]) begin found = 1'b1; break; end
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid) begin lat = k; break; end
    end
    check("valid_seen", 64'(found), 64'd1);
    check("latency_1beat", 64'(lat), 64'd2);
    wait_drain(200);
    check("ones_count", 64'(log_q[0].count), 64'd64);
    check("ones_beats", 64'(log_q[0].beats), 64'd1);

    // single source, req 2: 0xFF, 0, all ones
    log_q.delete();
    enq_beat(2, 64'hFF, 1'b0);
    enq_beat(2, 64'h0, 1'b0);
    enq_beat(2, '1, 1'b1);
    wait_drain(200);
    check("single_n", 64'(log_q.size()), 64'd1);
    check("single_count", 64'(log_q[0].count), 64'd72);
    check("single_id", 64'(log_q[0].id), 64'd2);
    check("single_beats", 64'(log_q[0].beats), 64'd3);
    check("single_trunc", 64'(log_q[0].trunc), 64'd0);

    // contention: two 1-beat packets per requester, all valid together
    do_reset();
    log_q.delete();
    for (int unsigned r = 0; r < NUM_REQ; r++) enq_pkt(r, 1, 0);
    for (int unsigned r = 0; r < NUM_REQ; r++) enq_pkt(r, 1, 3);
    wait_drain(500);
    check("contention_n", 64'(log_q.size()), 64'(2 * NUM_REQ));
    for (int i = 0; i < 2 * NUM_REQ; i++) check("contention_order", 64'(log_q[i].id), 64'(i % NUM_REQ));

    // truncation at MAX_BEATS, then exactly MAX_BEATS with last
    log_q.delete();
    enq_pkt(1, 17, 2);
    wait_drain(500);
    enq_pkt(2, 16, 2);
    wait_drain(500);
    check("trunc_n", 64'(log_q.size()), 64'd3);
    check("trunc0_count", 64'(log_q[0].count), 64'd1024);
    check("trunc0_beats", 64'(log_q[0].beats), 64'd16);
    check("trunc0_flag", 64'(log_q[0].trunc), 64'd1);
    check("trunc1_count", 64'(log_q[1].count), 64'd64);
    check("trunc1_beats", 64'(log_q[1].beats), 64'd1);
    check("trunc1_flag", 64'(log_q[1].trunc), 64'd0);
    check("full16_count", 64'(log_q[2].count), 64'd1024);
    check("full16_beats", 64'(log_q[2].beats), 64'd16);
    check("full16_flag", 64'(log_q[2].trunc), 64'd0);

    // backpressure: hold res_ready low
    log_q.delete();
    rdy_mode = 2;
    enq_pkt(1, 2, 0);
    enq_pkt(3, 3, 0);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (res_valid) begin found = 1'b1; break; end
    end
    check("bp_result_seen", 64'(found), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
    end
    rdy_mode = 1;
    wait_drain(500);
    check("bp_n", 64'(log_q.size()), 64'd2);

    // randomized traffic with bubbles and random result backpressure
    bubble_pct = 25;
    rdy_mode   = 0;
    for (int round = 0; round < 6; round++) begin
      for (int p = 0; p < 10; p++) begin
        enq_pkt($urandom_range(NUM_REQ - 1), $urandom_range(20, 1), $urandom_range(3));
      end
      repeat (50) @(negedge clk);
    end
    wait_drain(20000);

    // asynchronous reset after two beats of a packet
    bubble_pct = 0;
    rdy_mode   = 1;
    start = acc_total[1];
    enq_pkt(1, 4, 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (acc_total[1] >= start + 2) break;
    end
    @(posedge clk);
    #2;
    check("pre_reset_ready", 64'(req_ready), 64'd2);
    rst_n = 1'b0;
    #1;
    check_zero("async");
    do_reset();
    log_q.delete();
    enq_beat(1, 64'h0F, 1'b1);
    wait_drain(200);
    check("post_reset_n", 64'(log_q.size()), 64'd1);
    check("post_reset_count", 64'(log_q[0].count), 64'd4);
    check("post_reset_beats", 64'(log_q[0].beats), 64'd1);

`ifdef POPCNT_STATS_EN
    do_reset();
    enq_pkt(0, 1, 0);
    enq_pkt(0, 2, 0);
    enq_pkt(0, 3, 0);
    enq_pkt(3, 1, 0);
    wait_drain(500);
    stat_sel = ID_W'(0);
    #1;
    check("stat_pkts0", 64'(stat_pkts), 64'd3);
    stat_sel = ID_W'(3);
    #1;
    check("stat_pkts3", 64'(stat_pkts), 64'd1);
    stat_sel = ID_W'(1);
    #1;
    check("stat_pkts1", 64'(stat_pkts), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
